// File: rtl/mips_core_pkg.sv
// Shared core types and constants.
// Branch outcome encoding, address width, and the predictor table
// entry formats used by the fetch-side branch predictor.
package mips_core_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  // Pattern-table counters come out of reset weakly not-taken.
  localparam logic [1:0] BHT_COUNTER_RESET = 2'b01;

  // The tag field is sized for the smallest legal BTB index. Narrower
  // tags are stored zero-extended, so unused upper bits stay constant.
  localparam int BTB_TAG_MAX_BITS = ADDR_WIDTH - 3;

  typedef struct packed {
    logic                        valid;
    logic [BTB_TAG_MAX_BITS-1:0] tag;
    logic [ADDR_WIDTH-1:0]       target;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating counter.
// Ports:
//   count_i  current counter value
//   inc_i    1 = count up (taken), 0 = count down (not taken)
//   count_o  next counter value, held at 2'b11 / 2'b00 at the limits
module sat_counter2 (
  input  logic [1:0] count_i,
  input  logic       inc_i,
  output logic [1:0] count_o
);

  always_comb begin
    count_o = count_i;
    if (inc_i) begin
      if (count_i != 2'b11) count_o = count_i + 2'd1;
    end else begin
      if (count_i != 2'b00) count_o = count_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Fetch-side gshare branch predictor.
// Looks up the fetch PC combinationally in a direct-mapped tagged BTB and a
// gshare pattern table, and learns from branch resolutions reported by decode.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_pc                fetch PC to predict for
//   o_pred_valid        BTB hit for i_pc
//   o_pred_target       predicted target (0 on miss)
//   o_pred_prediction   predicted direction (NOT_TAKEN on miss)
//   i_res_valid         resolution strobe
//   i_res_pc            PC of the resolved branch
//   i_res_target        decoded target
//   i_res_prediction    direction that was predicted
//   i_res_outcome       direction actually taken
//   o_stat_branches     saturating count of resolutions
//   o_stat_mispredicts  saturating count of mispredicted resolutions
module branch_predictor_gshare
  import mips_core_pkg::*;
#(
  parameter int BHT_INDEX_BITS = 8,
  parameter int BTB_INDEX_BITS = 6,
  parameter int GHR_BITS       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  output logic                  o_pred_valid,
  output logic [ADDR_WIDTH-1:0] o_pred_target,
  output BranchOutcome          o_pred_prediction,
  input  logic                  i_res_valid,
  input  logic [ADDR_WIDTH-1:0] i_res_pc,
  input  logic [ADDR_WIDTH-1:0] i_res_target,
  input  BranchOutcome          i_res_prediction,
  input  BranchOutcome          i_res_outcome,
  output logic [31:0]           o_stat_branches,
  output logic [31:0]           o_stat_mispredicts
);

  localparam int BHT_ENTRIES = 1 << BHT_INDEX_BITS;
  localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;
  localparam int TAG_SHIFT   = BTB_INDEX_BITS + 2;

  if (GHR_BITS > BHT_INDEX_BITS) begin : g_ghr_check
    $error("GHR_BITS must not exceed BHT_INDEX_BITS");
  end
  if (BTB_INDEX_BITS < 1) begin : g_btb_check
    $error("BTB_INDEX_BITS must be at least 1");
  end

  logic [1:0]          bht_q [BHT_ENTRIES];
  btb_entry_t          btb_q [BTB_ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         stat_branches_q, stat_branches_d;
  logic [31:0]         stat_mispredicts_q, stat_mispredicts_d;

  // Two-bit PC alignment bits never take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_pc[1:0], i_res_pc[1:0]};

  // ---------------- lookup (purely combinational) ----------------
  logic [BTB_INDEX_BITS-1:0]   lk_btb_idx;
  logic [BTB_TAG_MAX_BITS-1:0] lk_tag;
  logic [BHT_INDEX_BITS-1:0]   lk_bht_idx;
  btb_entry_t                  lk_entry;
  logic                        lk_hit;

  assign lk_btb_idx = i_pc[BTB_INDEX_BITS+1:2];
  assign lk_tag     = BTB_TAG_MAX_BITS'(i_pc >> TAG_SHIFT);
  assign lk_bht_idx = i_pc[BHT_INDEX_BITS+1:2] ^ BHT_INDEX_BITS'(ghr_q);
  assign lk_entry   = btb_q[lk_btb_idx];
  assign lk_hit     = lk_entry.valid && (lk_entry.tag == lk_tag);

  always_comb begin
    o_pred_valid      = 1'b0;
    o_pred_target     = '0;
    o_pred_prediction = NOT_TAKEN;
    if (lk_hit) begin
      o_pred_valid      = 1'b1;
      o_pred_target     = lk_entry.target;
      o_pred_prediction = bht_q[lk_bht_idx][1] ? TAKEN : NOT_TAKEN;
    end
  end

  // ---------------- update path ----------------
  logic [BTB_INDEX_BITS-1:0] up_btb_idx;
  logic [BHT_INDEX_BITS-1:0] up_bht_idx;
  logic                      up_taken;
  logic [1:0]                up_cnt_d;
  btb_entry_t                up_entry_d;

  // Update index uses the history as it stands before this resolution shifts in.
  assign up_btb_idx = i_res_pc[BTB_INDEX_BITS+1:2];
  assign up_bht_idx = i_res_pc[BHT_INDEX_BITS+1:2] ^ BHT_INDEX_BITS'(ghr_q);
  assign up_taken   = (i_res_outcome == TAKEN);

  sat_counter2 u_sat_counter2 (
    .count_i (bht_q[up_bht_idx]),
    .inc_i   (up_taken),
    .count_o (up_cnt_d)
  );

  always_comb begin
    up_entry_d        = '0;
    up_entry_d.valid  = 1'b1;
    up_entry_d.tag    = BTB_TAG_MAX_BITS'(i_res_pc >> TAG_SHIFT);
    up_entry_d.target = i_res_target;
  end

  // Truncating the concatenation drops the oldest history bit.
  assign ghr_d = GHR_BITS'({ghr_q, up_taken});

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (stat_branches_q != 32'hFFFF_FFFF) stat_branches_d = stat_branches_q + 32'd1;
    if ((i_res_prediction != i_res_outcome) && (stat_mispredicts_q != 32'hFFFF_FFFF))
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_COUNTER_RESET;
      for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= '0;
      ghr_q              <= '0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (i_res_valid) begin
      bht_q[up_bht_idx]  <= up_cnt_d;
      btb_q[up_btb_idx]  <= up_entry_d;
      ghr_q              <= ghr_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign o_stat_branches    = stat_branches_q;
  assign o_stat_mispredicts = stat_mispredicts_q;

endmodule
